hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage MIPS core. Drives the `en`/`bubbleSel` inputs of the four inter-stage buffers (IF/ID, ID/EX, EX/ME, ME/WB) and the PC load enable. It handles:
- post-reset priming,
- load-use stalls,
- taken-branch flushes,
- memory wait stalls,
- halt.

It also keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline control unit for a 5-stage MIPS core. Generates
//                the PC load enable, branch redirect select and the load
//                enable / bubble select pairs of the IF/ID, ID/EX, EX/ME and
//                ME/WB buffers. Handles post-reset priming, load-use stalls,
//                taken-branch flushes, memory wait stalls and halt, and keeps
//                saturating stall / flush event counters.
//
//  Ports       : clk, reset            clock, synchronous active-high reset
//                memBusy               data memory not ready this cycle
//                rsID, rtID            sources of the instruction leaving IF/ID
//                opEX, rdEX            opcode / destination leaving ID/EX
//                opME, zeroME          opcode / zero flag leaving EX/ME
//                opWB                  opcode leaving ME/WB
//                pcEn, redirect        PC load enable, branch target select
//                en*, bub*             buffer load enables / nop selects
//                halted                core stopped
//                stallCount,flushCount saturating event counters
//
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int                opWidth  = 6,
    parameter int                regWidth = 5,
    parameter int                cntWidth = 16,
    parameter logic [opWidth-1:0] LW      = 6'b100011,
    parameter logic [opWidth-1:0] BEQ     = 6'b000100,
    parameter logic [opWidth-1:0] HALT    = 6'b111111
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memBusy,
    input  logic [regWidth-1:0] rsID,
    input  logic [regWidth-1:0] rtID,
    input  logic [opWidth-1:0]  opEX,
    input  logic [regWidth-1:0] rdEX,
    input  logic [opWidth-1:0]  opME,
    input  logic                zeroME,
    input  logic [opWidth-1:0]  opWB,
    output logic                pcEn,
    output logic                redirect,
    output logic                enIFID,
    output logic                enIDEX,
    output logic                enEXME,
    output logic                enMEWB,
    output logic                bubIFID,
    output logic                bubIDEX,
    output logic                bubEXME,
    output logic                bubMEWB,
    output logic                halted,
    output logic [cntWidth-1:0] stallCount,
    output logic [cntWidth-1:0] flushCount
);

    typedef enum logic [1:0] {
        PRIME  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0]          PRIME_LOAD = 2'd3;
    localparam logic [cntWidth-1:0] CNT_ONE    = {{(cntWidth-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [1:0]          primeCnt_q, primeCnt_d;
    logic [cntWidth-1:0] stallCount_q, stallCount_d;
    logic [cntWidth-1:0] flushCount_q, flushCount_d;

    logic                isHalt;
    logic                branchTaken;
    logic                loadUse;
    logic                incStall;
    logic                incFlush;

    // Hazard detection on the raw pipeline taps.
    assign isHalt      = (opWB == HALT);
    assign branchTaken = (opME == BEQ) && zeroME;
    // r0 is hard-wired to zero, so a load into it can never be a true dependency.
    assign loadUse     = (opEX == LW) && (rdEX != '0) &&
                         ((rdEX == rsID) || (rdEX == rtID));

    // ------------------------------------------------------------------
    // Next-state and Mealy output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        primeCnt_d = primeCnt_q;
        incStall   = 1'b0;
        incFlush   = 1'b0;

        pcEn       = 1'b0;
        redirect   = 1'b0;
        enIFID     = 1'b0;
        enIDEX     = 1'b0;
        enEXME     = 1'b0;
        enMEWB     = 1'b0;
        bubIFID    = 1'b0;
        bubIDEX    = 1'b0;
        bubEXME    = 1'b0;
        bubMEWB    = 1'b0;
        halted     = 1'b0;

        if (reset) begin
            // While reset is asserted the pipeline is flushed exactly as in
            // PRIME, whatever state the FSM happens to be in.
            {enIFID, enIDEX, enEXME, enMEWB}     = 4'b1111;
            {bubIFID, bubIDEX, bubEXME, bubMEWB} = 4'b1111;
        end else begin
            unique case (state_q)
                PRIME: begin
                    // Buffers have no reset: push nops through every stage
                    // until the pipeline holds only known-clean content.
                    {enIFID, enIDEX, enEXME, enMEWB}     = 4'b1111;
                    {bubIFID, bubIDEX, bubEXME, bubMEWB} = 4'b1111;
                    primeCnt_d = primeCnt_q - 2'd1;
                    if (primeCnt_q == 2'd0) begin
                        state_d = RUN;
                    end
                end

                RUN: begin
                    if (isHalt) begin
                        // Everything frozen; the halting instruction's
                        // writeback still completes this cycle.
                        state_d = HALTED;
                    end else if (memBusy) begin
                        // Full hold. A pending branch in EX/ME is kept and
                        // re-evaluated once memory is ready.
                        incStall = 1'b1;
                    end else if (branchTaken) begin
                        // Squash the three younger instructions; the branch
                        // itself moves on into ME/WB.
                        pcEn     = 1'b1;
                        redirect = 1'b1;
                        {enIFID, enIDEX, enEXME, enMEWB}     = 4'b1111;
                        {bubIFID, bubIDEX, bubEXME, bubMEWB} = 4'b1110;
                        incFlush = 1'b1;
                    end else if (loadUse) begin
                        // Hold PC and IF/ID one cycle, insert a nop into EX.
                        // Next cycle opEX is that nop, so no extra state.
                        {enIFID, enIDEX, enEXME, enMEWB}     = 4'b0111;
                        {bubIFID, bubIDEX, bubEXME, bubMEWB} = 4'b0100;
                        incStall = 1'b1;
                    end else begin
                        pcEn = 1'b1;
                        {enIFID, enIDEX, enEXME, enMEWB} = 4'b1111;
                    end
                end

                HALTED: begin
                    halted = 1'b1;
                end

                default: begin
                    // Unreachable encoding: recover by re-priming.
                    state_d    = PRIME;
                    primeCnt_d = PRIME_LOAD;
                end
            endcase
        end
    end

    // Saturating counter updates.
    always_comb begin
        stallCount_d = stallCount_q;
        flushCount_d = flushCount_q;
        if (incStall && !(&stallCount_q)) begin
            stallCount_d = stallCount_q + CNT_ONE;
        end
        if (incFlush && !(&flushCount_q)) begin
            flushCount_d = flushCount_q + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIME;
            primeCnt_q   <= PRIME_LOAD;
            stallCount_q <= '0;
            flushCount_q <= '0;
        end else begin
            state_q      <= state_d;
            primeCnt_q   <= primeCnt_d;
            stallCount_q <= stallCount_d;
            flushCount_q <= flushCount_d;
        end
    end

    assign stallCount = stallCount_q;
    assign flushCount = flushCount_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. A rule-level model of
//                the control unit predicts every output each cycle; directed
//                sequences exercise priming, load-use, branch, memory wait,
//                counter saturation, halt and reset re-entry, with literal
//                expectations at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_NOP  = 6'b000000;

    logic       clk = 1'b0;
    logic       reset;
    logic       memBusy;
    logic [4:0] rsID, rtID, rdEX;
    logic [5:0] opEX, opME, opWB;
    logic       zeroME;
    logic       pcEn, redirect;
    logic       enIFID, enIDEX, enEXME, enMEWB;
    logic       bubIFID, bubIDEX, bubEXME, bubMEWB;
    logic       halted;
    logic [15:0] stallCount, flushCount;

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .memBusy    (memBusy),
        .rsID       (rsID),
        .rtID       (rtID),
        .opEX       (opEX),
        .rdEX       (rdEX),
        .opME       (opME),
        .zeroME     (zeroME),
        .opWB       (opWB),
        .pcEn       (pcEn),
        .redirect   (redirect),
        .enIFID     (enIFID),
        .enIDEX     (enIDEX),
        .enEXME     (enEXME),
        .enMEWB     (enMEWB),
        .bubIFID    (bubIFID),
        .bubIDEX    (bubIDEX),
        .bubEXME    (bubEXME),
        .bubMEWB    (bubMEWB),
        .halted     (halted),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Rule-level model: cycles since reset, halt flag, plain int counters.
    // ------------------------------------------------------------------
    bit m_known = 1'b0;
    int m_since = 0;
    bit m_halt  = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic bit m_branch();
        return (opME == OP_BEQ) && zeroME;
    endfunction

    function automatic bit m_loaduse();
        return (opEX == OP_LW) && (rdEX != 5'd0) && (rdEX == rsID || rdEX == rtID);
    endfunction

    // {pcEn, redirect, enIFID, enIDEX, enEXME, enMEWB,
    //  bubIFID, bubIDEX, bubEXME, bubMEWB, halted}
    function automatic logic [10:0] m_ctl();
        if (reset || m_since < 4) return 11'b0_0_1111_1111_0;
        if (m_halt)               return 11'b0_0_0000_0000_1;
        if (opWB == OP_HALT)      return 11'b0_0_0000_0000_0;
        if (memBusy)              return 11'b0_0_0000_0000_0;
        if (m_branch())           return 11'b1_1_1111_1110_0;
        if (m_loaduse())          return 11'b0_0_0111_0100_0;
        return 11'b1_0_1111_0000_0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_known = 1'b1;
            m_since = 0;
            m_halt  = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else if (m_known) begin
            if (m_since < 4) begin
                m_since++;
            end else if (!m_halt) begin
                if (opWB == OP_HALT)  m_halt = 1'b1;
                else if (memBusy)     m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
                else if (m_branch())  m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
                else if (m_loaduse()) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("ctl", {21'd0, pcEn, redirect, enIFID, enIDEX, enEXME, enMEWB,
                        bubIFID, bubIDEX, bubEXME, bubMEWB, halted}, {21'd0, m_ctl()});
            chk("stallCount", {16'd0, stallCount}, m_stall);
            chk("flushCount", {16'd0, flushCount}, m_flush);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memBusy = 1'b0;
        rsID = 5'd0; rtID = 5'd0; rdEX = 5'd0;
        opEX = OP_NOP; opME = OP_NOP; opWB = OP_NOP;
        zeroME = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_bub", {28'd0, bubIFID, bubIDEX, bubEXME, bubMEWB}, 32'hF);
        chk("rst_pcEn_halted", {30'd0, pcEn, halted}, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        do_reset();

        // Priming: 4 cycles of full flush, no fetch.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("prime_pcEn", {31'd0, pcEn}, 32'd0);
            chk("prime_bub", {28'd0, bubIFID, bubIDEX, bubEXME, bubMEWB}, 32'hF);
            tick();
        end
        @(negedge clk);
        chk("run_pcEn", {31'd0, pcEn}, 32'd1);
        chk("run_bub", {28'd0, bubIFID, bubIDEX, bubEXME, bubMEWB}, 32'h0);
        chk("run_counters", {stallCount, flushCount}, 32'd0);
        tick();

        // Load-use on rs.
        opEX = OP_LW; rdEX = 5'd5; rsID = 5'd5;
        @(negedge clk);
        chk("lu_ctl", {29'd0, pcEn, enIFID, bubIDEX}, 32'b001);
        tick();
        idle();
        @(negedge clk);
        chk("lu_stall", {16'd0, stallCount}, 32'd1);
        chk("lu_clear_pcEn", {31'd0, pcEn}, 32'd1);
        tick();

        // Load into r0: no hazard.
        opEX = OP_LW; rdEX = 5'd0; rsID = 5'd0; rtID = 5'd0;
        @(negedge clk);
        chk("lu_r0_pcEn", {31'd0, pcEn}, 32'd1);
        tick();
        // Load-use on rt.
        opEX = OP_LW; rdEX = 5'd9; rsID = 5'd3; rtID = 5'd9;
        tick();
        idle();

        // Taken branch.
        opME = OP_BEQ; zeroME = 1'b1;
        @(negedge clk);
        chk("br_ctl", {27'd0, redirect, bubIFID, bubIDEX, bubEXME, bubMEWB}, 32'b11110);
        tick();
        idle();
        @(negedge clk);
        chk("br_flush", {16'd0, flushCount}, 32'd1);
        tick();

        // Not-taken branch.
        opME = OP_BEQ; zeroME = 1'b0;
        @(negedge clk);
        chk("brnt_redirect", {31'd0, redirect}, 32'd0);
        tick();

        // Branch beats load-use.
        opME = OP_BEQ; zeroME = 1'b1; opEX = OP_LW; rdEX = 5'd7; rsID = 5'd7;
        @(negedge clk);
        chk("prio_ctl", {30'd0, redirect, enIFID}, 32'b11);
        tick();
        idle();
        @(negedge clk);
        chk("prio_counts", {stallCount, flushCount}, {16'd2, 16'd2});
        tick();

        // Memory wait holds a pending branch; flush when memBusy drops.
        opME = OP_BEQ; zeroME = 1'b1; opEX = OP_LW; rdEX = 5'd7; rsID = 5'd7;
        memBusy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mbr_hold", {26'd0, pcEn, redirect, enIFID, enIDEX, enEXME, enMEWB}, 32'd0);
            tick();
        end
        memBusy = 1'b0;
        @(negedge clk);
        chk("mbr_flush", {31'd0, redirect}, 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("mbr_counts", {stallCount, flushCount}, {16'd4, 16'd3});
        tick();

        // Plain memory wait of 3 cycles.
        memBusy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        memBusy = 1'b0;
        @(negedge clk);
        chk("mw_stall", {16'd0, stallCount}, 32'd7);
        chk("mw_resume", {30'd0, pcEn, enIFID}, 32'b11);
        tick();

        // Reset mid-RUN restarts priming and clears counters.
        do_reset();
        @(negedge clk);
        chk("rerst_counts", {stallCount, flushCount}, 32'd0);
        chk("rerst_pcEn", {31'd0, pcEn}, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // Stall counter saturation.
        memBusy = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        memBusy = 1'b0;
        @(negedge clk);
        chk("sat_stall", {16'd0, stallCount}, 32'hFFFF);
        tick();
        opEX = OP_LW; rdEX = 5'd4; rtID = 5'd4;
        tick();
        idle();
        @(negedge clk);
        chk("sat_hold", {16'd0, stallCount}, 32'hFFFF);
        tick();

        // Halt: halted rises next cycle, stays with arbitrary inputs.
        opWB = OP_HALT;
        @(negedge clk);
        chk("halt_cycle", {29'd0, pcEn, enIFID, halted}, 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            memBusy = 1'($urandom_range(0, 1));
            opEX = OP_LW; rdEX = 5'($urandom_range(1, 31)); rsID = rdEX;
            opME = OP_BEQ; zeroME = 1'b1; opWB = 6'($urandom_range(0, 63));
            @(negedge clk);
            chk("halted", {27'd0, halted, enIFID, enIDEX, enEXME, enMEWB}, 32'b10000);
            tick();
        end
        idle();

        // Reset out of HALTED.
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        chk("post_halt_run", {30'd0, pcEn, halted}, 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
